// File: rtl/logic_unit_arbiter_pkg.sv
// =============================================================================
// Module : logic_unit_arbiter_pkg
// Brief  : Op codes and sequencer states shared by the logic-unit arbiter.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

package logic_unit_arbiter_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/logic_rr_picker.sv
// =============================================================================
// Module : logic_rr_picker
// Brief  : Combinational round-robin pick: first set req bit at or above ptr,
//          wrapping at NUM_REQ-1.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module logic_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               valid
);

    int idx;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        idx        = 0;
        // Scan farthest offset first so the nearest requester overwrites last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (req[idx]) begin
                winner     = NUM_REQ'(1) << idx;
                winner_idx = IDX_W'(idx);
                valid      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
// =============================================================================
// Module : logic_unit_arbiter
// Brief  : Round-robin shared AND/OR/XOR/NAND unit; optional back-to-back
//          grants when LOGICARB_BACK2BACK_EN is defined.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [2*NUM_REQ-1:0]      op_flat,
    input  logic [NUM_REQ*DATA_W-1:0] a_flat,
    input  logic [NUM_REQ*DATA_W-1:0] b_flat,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         result,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t              state_q,   state_d;
    logic [NUM_REQ-1:0]  gnt_q,     gnt_d;
    logic [NUM_REQ-1:0]  done_q,    done_d;
    logic [DATA_W-1:0]   result_q,  result_d;
    logic [IDX_W-1:0]    ptr_q,     ptr_d;
    logic [IDX_W-1:0]    win_idx_q, win_idx_d;
    logic [1:0]          op_q,      op_d;
    logic [DATA_W-1:0]   a_q,       a_d;
    logic [DATA_W-1:0]   b_q,       b_d;

    logic [1:0]          op_arr [NUM_REQ];
    logic [DATA_W-1:0]   a_arr  [NUM_REQ];
    logic [DATA_W-1:0]   b_arr  [NUM_REQ];

    logic [NUM_REQ-1:0]  pick_req;
    logic [IDX_W-1:0]    pick_ptr;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [IDX_W-1:0]    ptr_after_win;
    logic [DATA_W-1:0]   alu_out;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign op_arr[gi] = op_flat[2*gi +: 2];
        assign a_arr[gi]  = a_flat[gi*DATA_W +: DATA_W];
        assign b_arr[gi]  = b_flat[gi*DATA_W +: DATA_W];
    end

    assign ptr_after_win = (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + 1'b1;

    // In DONE the picker looks ahead from the post-grant pointer with the
    // just-served requester masked out; elsewhere it uses the live pointer.
    always_comb begin
        pick_req = req;
        pick_ptr = ptr_q;
        if (state_q == S_DONE) begin
            pick_req = req & ~gnt_q;
            pick_ptr = ptr_after_win;
        end
    end

    logic_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (pick_req),
        .ptr        (pick_ptr),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    always_comb begin
        case (op_q)
            OP_AND:  alu_out = a_q & b_q;
            OP_OR:   alu_out = a_q | b_q;
            OP_XOR:  alu_out = a_q ^ b_q;
            default: alu_out = ~(a_q & b_q);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        result_d  = result_q;
        ptr_d     = ptr_q;
        win_idx_d = win_idx_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    gnt_d     = pick_onehot;
                    win_idx_d = pick_idx;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                op_d    = op_arr[win_idx_q];
                a_d     = a_arr[win_idx_q];
                b_d     = b_arr[win_idx_q];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d = alu_out;
                done_d   = gnt_q;
                state_d  = S_DONE;
            end
            S_DONE: begin
                ptr_d   = ptr_after_win;
                gnt_d   = '0;
                state_d = S_IDLE;
`ifdef LOGICARB_BACK2BACK_EN
                if (pick_valid) begin
                    gnt_d     = pick_onehot;
                    win_idx_d = pick_idx;
                    state_d   = S_LOAD;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            result_q  <= '0;
            ptr_q     <= '0;
            win_idx_q <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            result_q  <= result_d;
            ptr_q     <= ptr_d;
            win_idx_q <= win_idx_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign result = result_q;
    assign busy   = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
// =============================================================================
// Module : tb_logic_unit_arbiter
// Brief  : Directed + randomized bench against a transaction-level model.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_logic_unit_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
`ifdef LOGICARB_BACK2BACK_EN
    localparam int PERIOD = 3;
`else
    localparam int PERIOD = 4;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [2*N-1:0]  op_flat;
    logic [N*DW-1:0] a_flat;
    logic [N*DW-1:0] b_flat;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [DW-1:0]   result;
    logic            busy;

    logic [N-1:0]    req_v;
    logic [1:0]      op_v [N];
    logic [DW-1:0]   a_v  [N];
    logic [DW-1:0]   b_v  [N];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int g_cyc    = 0;
    int ptr_m    = 0;
    logic [N-1:0] prev_gnt  = '0;
    logic [N-1:0] prev_done = '0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .op_flat (op_flat),
        .a_flat  (a_flat),
        .b_flat  (b_flat),
        .gnt     (gnt),
        .done    (done),
        .result  (result),
        .busy    (busy)
    );

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return 0;
    endfunction

    function automatic logic [DW-1:0] ref_logic(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic apply();
        req = req_v;
        for (int i = 0; i < N; i++) begin
            op_flat[2*i +: 2] = op_v[i];
            a_flat[i*DW +: DW] = a_v[i];
            b_flat[i*DW +: DW] = b_v[i];
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        prev_gnt  = gnt;
        prev_done = done;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_grant(output int found);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (gnt != '0 && (prev_gnt == '0 || prev_done != '0)) begin
                found = 1;
                g_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic randomize_operands();
        for (int i = 0; i < N; i++) begin
            op_v[i] = 2'($urandom);
            a_v[i]  = DW'($urandom);
            b_v[i]  = DW'($urandom);
        end
    endtask

    // One full transaction: grant, load, exec, done. drop is removed from req in EXEC.
    task automatic run_txn(input string tag, input logic [N-1:0] drop, output int widx);
        int found;
        int exp_i;
        logic [N-1:0] oh;
        exp_i = rr_pick(req_v, ptr_m);
        oh    = N'(1) << exp_i;
        wait_grant(found);
        check({tag, "_grant_seen"}, 32'(found), 32'd1);
        check({tag, "_gnt_load"}, 32'(gnt), 32'(oh));
        check({tag, "_busy_load"}, 32'(busy), 32'd1);
        check({tag, "_done_load"}, 32'(done), 32'd0);
        step();
        req_v = req_v & ~drop;
        apply();
        check({tag, "_gnt_exec"}, 32'(gnt), 32'(oh));
        check({tag, "_done_exec"}, 32'(done), 32'd0);
        step();
        check({tag, "_gnt_done"}, 32'(gnt), 32'(oh));
        check({tag, "_done_pulse"}, 32'(done), 32'(oh));
        check({tag, "_result"}, 32'(result), 32'(ref_logic(op_v[exp_i], a_v[exp_i], b_v[exp_i])));
        ptr_m = (exp_i + 1) % N;
        widx  = exp_i;
    endtask

    task automatic check_idle(input string tag);
        step();
        check({tag, "_idle_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int w;
        int last_g;
        int found;

        // Reset held with all requesters asking
        rst_n = 1'b0;
        req_v = '1;
        randomize_operands();
        apply();
        repeat (3) step();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        ptr_m = 0;
        run_txn("first", '0, w);
        req_v = '0;
        apply();
        check_idle("first");

        // Requester 0 AND vector
        op_v[0] = 2'd0; a_v[0] = 8'hF0; b_v[0] = 8'h3C;
        req_v = 4'b0001;
        apply();
        run_txn("and0", '0, w);
        check("and0_vec", 32'(result), 32'h30);
        req_v = '0;
        apply();
        check_idle("and0");
        check("and0_result_held", 32'(result), 32'h30);

        // Op coverage on requester 2
        op_v[2] = 2'd2; a_v[2] = 8'hA5; b_v[2] = 8'h0F;
        req_v = 4'b0100; apply();
        run_txn("xor2", '0, w);
        check("xor2_vec", 32'(result), 32'hAA);
        req_v = '0; apply();
        check_idle("xor2");

        op_v[2] = 2'd1; a_v[2] = 8'h50; b_v[2] = 8'h05;
        req_v = 4'b0100; apply();
        run_txn("or2", '0, w);
        check("or2_vec", 32'(result), 32'h55);
        req_v = '0; apply();
        check_idle("or2");

        op_v[2] = 2'd3; a_v[2] = 8'hFF; b_v[2] = 8'hFF;
        req_v = 4'b0100; apply();
        run_txn("nand2", '0, w);
        check("nand2_vec", 32'(result), 32'h00);
        req_v = '0; apply();
        check_idle("nand2");

        // Randomized patterns against the model
        for (int t = 0; t < 8; t++) begin
            randomize_operands();
            req_v = N'($urandom_range(1, (1 << N) - 1));
            apply();
            run_txn("rand", '0, w);
            req_v = '0;
            apply();
            check_idle("rand");
        end

        // Full contention from a fresh pointer: order 0,1,2,3,0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ptr_m = 0;
        randomize_operands();
        req_v = '1;
        apply();
        last_g = 0;
        for (int t = 0; t < 5; t++) begin
            run_txn("rr", '0, w);
            check("rr_order", 32'(gnt), 32'(N'(1) << (t % N)));
            if (t > 0) check("rr_period", 32'(g_cyc - last_g), 32'(PERIOD));
            last_g = g_cyc;
        end
        req_v = '0;
        apply();
        check_idle("rr");

        // Requester 1 withdraws during EXEC; requester 3 still pending
        randomize_operands();
        req_v = 4'b1010;
        apply();
        run_txn("drop", 4'b0010, w);
        check("drop_winner", 32'(gnt), 32'h2);
        run_txn("after_drop", '0, w);
        check("after_drop_gnt", 32'(gnt), 32'h8);
        req_v = '0;
        apply();
        check_idle("after_drop");

        // Asynchronous reset during EXEC aborts the transaction
        randomize_operands();
        req_v = 4'b0110;
        apply();
        wait_grant(found);
        check("abort_grant_seen", 32'(found), 32'd1);
        check("abort_gnt", 32'(gnt), 32'(N'(1) << rr_pick(req_v, ptr_m)));
        step();
        rst_n = 1'b0;
        #1;
        check("abort_gnt_clr", 32'(gnt), 32'd0);
        check("abort_done_clr", 32'(done), 32'd0);
        check("abort_busy_clr", 32'(busy), 32'd0);
        check("abort_result_clr", 32'(result), 32'd0);
        step();
        check("abort_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        ptr_m = 0;
        run_txn("post_abort", '0, w);
        check("post_abort_gnt", 32'(gnt), 32'h2);
        req_v = '0;
        apply();
        check_idle("post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
